// File: rtl/skynet_mul_accum_out.sv
// Group accumulator behind the SkyNet 9s x 11s DSP multiplier: sums one in_last-terminated burst of
// products, requantises with round-half-up shift plus saturation, and emits one result per group.
module skynet_mul_accum_out #(
  parameter int unsigned PROD_W = 20,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_sat,
  output logic              acc_ovf
);

  // One guard bit above the accumulator so the rounding add can never wrap.
  localparam int unsigned EXT_W  = ACC_W + 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EXT_W-1:0] RND = (SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
  localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    out_sat_q, out_sat_d;
  logic                    acc_ovf_q, acc_ovf_d;

  logic                    accept;
  logic                    emit;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic signed [EXT_W-1:0] rnd_sum;
  logic signed [EXT_W-1:0] rsh;
  logic [OUT_W-1:0]        req_data;
  logic                    req_sat;
  logic [CNT_W-1:0]        cnt_inc;

  // Single output register: a new beat may enter whenever the slot is empty or draining now.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid_q && out_ready;

  // Running sum including the current beat, with signed-overflow detection on the add.
  always_comb begin
    prod_ext = {{(ACC_W - PROD_W){in_data[PROD_W-1]}}, in_data};
    sum      = acc_q + prod_ext;
    add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    cnt_inc  = cnt_q + CNT_W'(1);
  end

  // Round half up, arithmetic shift, then clip into the signed output range.
  always_comb begin
    rnd_sum  = $signed({sum[ACC_W-1], sum}) + $signed(RND);
    rsh      = rnd_sum >>> SHIFT;
    req_sat  = 1'b0;
    req_data = rsh[OUT_W-1:0];
    if (rsh > OUT_MAX) begin
      req_sat  = 1'b1;
      req_data = OUT_MAX[OUT_W-1:0];
    end else if (rsh < OUT_MIN) begin
      req_sat  = 1'b1;
      req_data = OUT_MIN[OUT_W-1:0];
    end
  end

  // Next-state: drain the output slot, then let a closing beat refill it on the same edge.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_sat_d   = out_sat_q;
    acc_ovf_d   = acc_ovf_q;

    if (emit) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (add_ovf) begin
        acc_ovf_d = 1'b1;
      end
      if (in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = req_data;
        out_cnt_d   = cnt_inc;
        out_sat_d   = req_sat;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_sat_q   <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_sat_q   <= out_sat_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_sat   = out_sat_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_skynet_mul_accum_out.sv
// Self-checking bench for skynet_mul_accum_out: scoreboard of expected group results plus
// per-scenario inline checks of handshake, latency, reset and overflow behaviour.
module tb_skynet_mul_accum_out;

  localparam int SHIFT = 8;

  typedef struct {
    logic [15:0] data;
    logic [11:0] cnt;
    logic        sat;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [11:0] out_cnt;
  logic        out_sat;
  logic        acc_ovf;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [19:0] in_data2 = '0;
  logic        in_last2 = 1'b0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [15:0] out_data2;
  logic [11:0] out_cnt2;
  logic        out_sat2;
  logic        acc_ovf2;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 ap_clk = ~ap_clk;

  skynet_mul_accum_out #(
    .PROD_W(20), .ACC_W(32), .CNT_W(12), .OUT_W(16), .SHIFT(8)
  ) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt),
    .out_sat(out_sat), .acc_ovf(acc_ovf)
  );

  skynet_mul_accum_out #(
    .PROD_W(20), .ACC_W(24), .CNT_W(12), .OUT_W(16), .SHIFT(8)
  ) u_dut24 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_cnt(out_cnt2),
    .out_sat(out_sat2), .acc_ovf(acc_ovf2)
  );

  // Reference requantiser: floor((sum + 2^(SHIFT-1)) / 2^SHIFT), clipped to 16-bit signed.
  function automatic exp_t model(input longint sum, input int n);
    exp_t   e;
    longint r;
    r = (sum + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    e.sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      e.sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      e.sat = 1'b1;
    end
    e.data = 16'(r);
    e.cnt  = 12'(n);
    return e;
  endfunction

  // Scoreboard: every completed output handshake must match the oldest expected result.
  always @(negedge ap_clk) begin
    if (!ap_rst && out_valid && out_ready) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got data=%0d cnt=%0d, required no result", $signed(out_data), out_cnt);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_cnt !== mon_e.cnt || out_sat !== mon_e.sat)
          $display("FAIL sb_result: got data=%0d cnt=%0d sat=%b, required data=%0d cnt=%0d sat=%b",
                   $signed(out_data), out_cnt, out_sat, $signed(mon_e.data), mon_e.cnt, mon_e.sat);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic drive_beat(input int d, input logic l);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = 20'(d);
    in_last  = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge ap_clk);
      if (in_ready) begin
        @(posedge ap_clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL beat_accept_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge ap_clk);
    #1;
    n_total++;
    if ({out_valid, out_data, out_cnt, out_sat, acc_ovf} !== '0)
      $display("FAIL reset_outputs: got valid=%b data=%0d cnt=%0d sat=%b ovf=%b, required all 0",
               out_valid, out_data, out_cnt, out_sat, acc_ovf);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else n_pass++;
    ap_rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_group;
    out_ready = 1'b1;
    sb.push_back(model(256 + 512 - 256, 3));
    drive_beat(256, 1'b0);
    drive_beat(512, 1'b0);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL basic_no_early_result: got out_valid=%b required 0", out_valid);
    else n_pass++;
    drive_beat(-256, 1'b1);
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL basic_latency: got out_valid=%b required 1", out_valid);
    else n_pass++;
    n_total++;
    if (out_data !== 16'd2) $display("FAIL basic_data: got %0d required 2", $signed(out_data));
    else n_pass++;
    idle(2);
  endtask

  task automatic test_back_to_back;
    int   vals[3] = '{128, -128, -129};
    time  t0;
    out_ready = 1'b1;
    t0 = $time;
    foreach (vals[i]) begin
      sb.push_back(model(vals[i], 1));
      drive_beat(vals[i], 1'b1);
      n_total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1)
        $display("FAIL b2b_flow_%0d: got in_ready=%b out_valid=%b required 1/1", i, in_ready, out_valid);
      else n_pass++;
    end
    n_total++;
    if ($time - t0 !== 30) $display("FAIL b2b_cycles: got %0t time units required 30", $time - t0);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    sb.push_back(model(longint'(20) * 524287, 20));
    for (int i = 1; i <= 20; i++) drive_beat(524287, i == 20);
    n_total++;
    if (out_sat !== 1'b1 || out_data !== 16'h7fff)
      $display("FAIL sat_pos: got data=%0d sat=%b required 32767/1", $signed(out_data), out_sat);
    else n_pass++;
    sb.push_back(model(longint'(20) * -524288, 20));
    for (int i = 1; i <= 20; i++) drive_beat(-524288, i == 20);
    n_total++;
    if (out_sat !== 1'b1 || out_data !== 16'h8000)
      $display("FAIL sat_neg: got data=%0d sat=%b required -32768/1", $signed(out_data), out_sat);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    sb.push_back(model(256, 1));
    drive_beat(256, 1'b1);
    // A closing beat offered while stalled must be ignored.
    in_valid = 1'b1;
    in_data  = 20'(1000);
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b required 0", i, in_ready);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 16'd1 || out_cnt !== 12'd1 || out_sat !== 1'b0)
        $display("FAIL bp_stable_%0d: got valid=%b data=%0d cnt=%0d sat=%b required 1/1/1/0",
                 i, out_valid, $signed(out_data), out_cnt, out_sat);
      else n_pass++;
    end
    @(posedge ap_clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_release: got in_ready=%b required 1", in_ready);
    else n_pass++;
    idle(3);
  endtask

  task automatic test_reset_mid_group;
    out_ready = 1'b1;
    drive_beat(1000, 1'b0);
    drive_beat(2000, 1'b0);
    ap_rst = 1'b1;
    idle(1);
    ap_rst = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || out_cnt !== 12'd0)
      $display("FAIL midrst_clear: got valid=%b cnt=%0d required 0/0", out_valid, out_cnt);
    else n_pass++;
    sb.push_back(model(256, 1));
    drive_beat(256, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 16'd1 || out_cnt !== 12'd1)
      $display("FAIL midrst_result: got valid=%b data=%0d cnt=%0d required 1/1/1",
               out_valid, $signed(out_data), out_cnt);
    else n_pass++;
    idle(2);
    n_total++;
    if (acc_ovf !== 1'b0) $display("FAIL no_ovf_32: got acc_ovf=%b required 0", acc_ovf);
    else n_pass++;
  endtask

  task automatic test_acc_overflow;
    out_ready2 = 1'b1;
    n_total++;
    if (acc_ovf2 !== 1'b0) $display("FAIL ovf_initial: got %b required 0", acc_ovf2);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      in_valid2 = 1'b1;
      in_data2  = 20'(524287);
      in_last2  = (i == 39);
      @(posedge ap_clk);
      #1;
      // 16 beats still fit in 24 bits; the 17th overflows.
      if (i == 15) begin
        n_total++;
        if (acc_ovf2 !== 1'b0) $display("FAIL ovf_beat16: got %b required 0", acc_ovf2);
        else n_pass++;
      end
      if (i == 16) begin
        n_total++;
        if (acc_ovf2 !== 1'b1) $display("FAIL ovf_beat17: got %b required 1", acc_ovf2);
        else n_pass++;
      end
    end
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    n_total++;
    if (acc_ovf2 !== 1'b1 || out_valid2 !== 1'b1 || out_cnt2 !== 12'd40)
      $display("FAIL ovf_emit: got ovf=%b valid=%b cnt=%0d required 1/1/40", acc_ovf2, out_valid2, out_cnt2);
    else n_pass++;
    in_valid2 = 1'b1;
    in_data2  = 20'(256);
    in_last2  = 1'b1;
    idle(1);
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    idle(3);
    n_total++;
    if (acc_ovf2 !== 1'b1 || out_cnt2 !== 12'd1)
      $display("FAIL ovf_sticky: got ovf=%b cnt=%0d required 1/1", acc_ovf2, out_cnt2);
    else n_pass++;
    ap_rst = 1'b1;
    idle(1);
    ap_rst = 1'b0;
    n_total++;
    if (acc_ovf2 !== 1'b0) $display("FAIL ovf_reset: got %b required 0", acc_ovf2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_group();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_reset_mid_group();
    test_acc_overflow();
    idle(3);
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d results outstanding required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
